rc5_core_param: RTL and testbench
=================================

// Module: rc5_core_param
// PURPOSE
//  Parametrised RC5-W/r/b block cipher engine, successor to the fixed 16-bit algo core.
//  Word width, maximum round count and subkey table are generic. Subkeys are loaded at
//  run time through a write port, not hard-coded. Runtime round count is selected per block.
//  Valid/ready handshakes on input and output. One round is computed per clock.
//  Decrypt runs rounds r..1 in proper reverse order, then removes the whitening.
//  The block sits between the host register interface and the key-schedule unit.
// PARAMETERS
//  W           16   word width in bits; legal values are 16 and 32; block size is 2*W
//  MAX_ROUNDS  16   largest supported round count; subkey table has 2*MAX_ROUNDS+2 entries
//  RW          $clog2(MAX_ROUNDS+1)    width of in_rounds (derived)
//  SKW         $clog2(2*MAX_ROUNDS+2)  width of sk_addr (derived)
// PORTS
//  clk         in   1     clock, rising edge
//  rst         in   1     asynchronous, active-low reset
//  sk_we       in   1     subkey write strobe
//  sk_addr     in   SKW   subkey index
//  sk_wdata    in   W     subkey value
//  in_valid    in   1     block offered
//  in_ready    out  1     block accepted when in_valid & in_ready
//  in_decrypt  in   1     0 = encrypt, 1 = decrypt (sampled at accept)
//  in_rounds   in   RW    round count r (sampled at accept; 0 legal)
//  in_data     in   2W    {B,A}; A = in_data[W-1:0]
//  out_valid   out  1     result available
//  out_ready   in   1     consumer takes result when out_valid & out_ready
//  out_data    out  2W    result {B,A}
//  busy        out  1     high in ROUND or DONE
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE; A,B=0; round counter=0; all subkeys=0.
//    Outputs in_ready=0 while rst=0 and 1 after release; out_valid=0; busy=0; out_data=0.
//    A reset mid-block discards that block, and out_valid drops immediately.
//  - Subkey table: 2*MAX_ROUNDS+2 W-bit flops with async read.
//    A write is honoured only in IDLE when sk_addr < 2*MAX_ROUNDS+2; otherwise it is silently dropped.
//  - FSM states:
//    - IDLE: in_ready=1. On accept, latch mode and rc = min(in_rounds, MAX_ROUNDS).
//      Encrypt: A=in_A+S[0], B=in_B+S[1]. Decrypt: A=in_A, B=in_B.
//      Next state = (rc==0) ? DONE : ROUND. Round index i=1 for encrypt, i=rc for decrypt.
//    - ROUND: one round per edge.
//      Encrypt: A'=((A^B)<<<B)+S[2i], then B'=((B^A')<<<A')+S[2i+1]; i increments.
//      Decrypt: B'=((B-S[2i+1])>>>A)^A, then A'=((A-S[2i])>>>B')^B'; i decrements.
//      Leave for DONE after the rc-th round.
//    - DONE: out_valid=1. out_data={B,A} for encrypt, {B-S[1],A-S[0]} for decrypt.
//      out_data is held stable until out_ready=1, then go to IDLE.
//  - Arithmetic: all add/sub is modulo 2^W. Rotate amount is the low $clog2(W) bits of the
//    controlling word; an amount of 0 leaves the word unchanged.
//  - Latency: counting the accept cycle as cycle 0, out_valid is first high in cycle rc+1.
//    Throughput is one block per rc+2 cycles when out_ready is held high.
//  - in_ready=0 in ROUND and DONE, so there is no overlap of blocks. in_* is ignored while busy.
//  - Changing subkeys between blocks takes effect on the next accepted block.
// TESTING
//  1. W=32, MAX_ROUNDS=12. Load S for the all-zero 16-byte key (bench key schedule).
//     Encrypt 0, r=12 -> out_data=64'h6D8F4B15_EEDBA521; out_valid in cycle 13.
//  2. Same setup: decrypt 64'h6D8F4B15_EEDBA521, r=12 -> out_data=0.
//     Also encrypt then decrypt 1000 random blocks with random r in 0..12 -> original plaintext.
//  3. W=16: S[0]=1, S[1]=2. Encrypt 32'h0003_0005, r=0 -> 32'h0005_0006 in cycle 1.
//     Decrypt 32'h0005_0006, r=0 -> 32'h0003_0005.
//  4. Backpressure: hold out_ready=0 for 10 cycles -> out_data/out_valid stable, in_ready=0.
//     Then out_ready=1 -> IDLE next cycle, and the next block is accepted.
//  5. in_rounds=MAX_ROUNDS+3 -> result equals an r=MAX_ROUNDS run.
//     sk_we during ROUND -> table unchanged (readback via a subsequent encrypt).
//  6. Assert rst low mid-ROUND -> out_valid=0 at once. After release: in_ready=1,
//     the subkey table is all zero, and the next block encrypts with zero subkeys.

Source files
------------

// File: rtl/rc5_core_param.sv
// RC5-W/r/b block cipher engine: runtime-loadable subkey table, per-block round count,
// one round per clock, valid/ready on both sides.
module rc5_core_param #(
    parameter int W          = 16,
    parameter int MAX_ROUNDS = 16,
    parameter int RW         = $clog2(MAX_ROUNDS + 1),
    parameter int SKW        = $clog2(2 * MAX_ROUNDS + 2)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           sk_we,
    input  logic [SKW-1:0] sk_addr,
    input  logic [W-1:0]   sk_wdata,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           in_decrypt,
    input  logic [RW-1:0]  in_rounds,
    input  logic [2*W-1:0] in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] out_data,
    output logic           busy
);

    localparam int NSK = 2 * MAX_ROUNDS + 2;
    localparam int LGW = $clog2(W);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // valid never waits for ready, and a producer holds its payload stable until transfer.
    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    state_t         state;
    logic [W-1:0]   a, b;
    logic [RW-1:0]  idx, rc;
    logic           dec;
    logic [W-1:0]   s_tab [NSK];

    function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [W-1:0] amt);
        logic [2*W-1:0] t;
        t = {x, x} << amt[LGW-1:0];
        return t[2*W-1:W];
    endfunction

    function automatic logic [W-1:0] rotr(input logic [W-1:0] x, input logic [W-1:0] amt);
        logic [2*W-1:0] t;
        t = {x, x} >> amt[LGW-1:0];
        return t[W-1:0];
    endfunction

    logic [SKW-1:0] ia, ib;
    logic [W-1:0]   sa, sb, s0, s1;
    logic [W-1:0]   enc_a, enc_b, dec_a, dec_b, nxt_a, nxt_b;
    logic [W-1:0]   in_a, in_b, ld_a, ld_b;
    logic [RW-1:0]  rc_sat;
    logic           last;
    logic [2*W-1:0] fin_acc, fin_rnd;

    assign ia = SKW'({idx, 1'b0});
    assign ib = SKW'({idx, 1'b1});
    assign sa = s_tab[ia];
    assign sb = s_tab[ib];
    assign s0 = s_tab[0];
    assign s1 = s_tab[1];

    always_comb begin
        enc_a   = rotl(a ^ b, b) + sa;
        enc_b   = rotl(b ^ enc_a, enc_a) + sb;
        dec_b   = rotr(b - sb, a) ^ a;
        dec_a   = rotr(a - sa, dec_b) ^ dec_b;
        nxt_a   = dec ? dec_a : enc_a;
        nxt_b   = dec ? dec_b : enc_b;
        last    = dec ? (idx == RW'(1)) : (idx == rc);
        in_a    = in_data[W-1:0];
        in_b    = in_data[2*W-1:W];
        rc_sat  = (in_rounds > RW'(MAX_ROUNDS)) ? RW'(MAX_ROUNDS) : in_rounds;
        ld_a    = in_decrypt ? in_a : in_a + s0;
        ld_b    = in_decrypt ? in_b : in_b + s1;
        // Decrypt strips the input whitening as the result is registered.
        fin_acc = in_decrypt ? {ld_b - s1, ld_a - s0} : {ld_b, ld_a};
        fin_rnd = dec ? {nxt_b - s1, nxt_a - s0} : {nxt_b, nxt_a};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            a         <= '0;
            b         <= '0;
            idx       <= '0;
            rc        <= '0;
            dec       <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
            for (int k = 0; k < NSK; k++) s_tab[k] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (sk_we && ({1'b0, sk_addr} < (SKW + 1)'(NSK)))
                        s_tab[sk_addr] <= sk_wdata;
                    if (in_valid && in_ready) begin
                        dec      <= in_decrypt;
                        rc       <= rc_sat;
                        a        <= ld_a;
                        b        <= ld_b;
                        idx      <= in_decrypt ? rc_sat : RW'(1);
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        if (rc_sat == '0) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            out_data  <= fin_acc;
                        end else begin
                            state <= ROUND;
                        end
                    end
                end
                ROUND: begin
                    a   <= nxt_a;
                    b   <= nxt_b;
                    idx <= dec ? idx - RW'(1) : idx + RW'(1);
                    if (last) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out_data  <= fin_rnd;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rc5_core_param.sv
// Bench for rc5_core_param (W=32, 12 rounds): behavioural RC5 model with a per-cycle
// compare process, known-answer vectors, random encrypt/decrypt round trips and reset cases.
module tb_rc5_core_param;

    localparam int W   = 32;
    localparam int MR  = 12;
    localparam int RW  = 4;
    localparam int SKW = 5;
    localparam int NSK = 26;

    logic           clk, rst, sk_we;
    logic [SKW-1:0] sk_addr;
    logic [W-1:0]   sk_wdata;
    logic           in_valid, in_ready, in_decrypt;
    logic [RW-1:0]  in_rounds;
    logic [63:0]    in_data;
    logic           out_valid, out_ready;
    logic [63:0]    out_data;
    logic           busy;

    rc5_core_param #(.W(W), .MAX_ROUNDS(MR)) dut (
        .clk(clk), .rst(rst), .sk_we(sk_we), .sk_addr(sk_addr), .sk_wdata(sk_wdata),
        .in_valid(in_valid), .in_ready(in_ready), .in_decrypt(in_decrypt),
        .in_rounds(in_rounds), .in_data(in_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s: timed out waiting for DUT at %0t", name, $time);
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_sk [NSK];
    logic [31:0] sched [NSK];
    logic [63:0] exp_q [$];
    int          wait_cnt;
    bit          model_on;

    function automatic logic [31:0] rl(input logic [31:0] x, input logic [31:0] n);
        int k;
        k = int'(n % 32);
        if (k == 0) return x;
        return (x << k) | (x >> (32 - k));
    endfunction

    function automatic logic [31:0] rr(input logic [31:0] x, input logic [31:0] n);
        int k;
        k = int'(n % 32);
        if (k == 0) return x;
        return (x >> k) | (x << (32 - k));
    endfunction

    function automatic logic [63:0] m_enc(input logic [63:0] p, input int r);
        logic [31:0] ma, mb;
        ma = p[31:0] + m_sk[0];
        mb = p[63:32] + m_sk[1];
        for (int i = 1; i <= r; i++) begin
            ma = rl(ma ^ mb, mb) + m_sk[2*i];
            mb = rl(mb ^ ma, ma) + m_sk[2*i+1];
        end
        return {mb, ma};
    endfunction

    function automatic logic [63:0] m_dec(input logic [63:0] c, input int r);
        logic [31:0] ma, mb;
        ma = c[31:0];
        mb = c[63:32];
        for (int i = r; i >= 1; i--) begin
            mb = rr(mb - m_sk[2*i+1], ma) ^ ma;
            ma = rr(ma - m_sk[2*i], mb) ^ mb;
        end
        return {mb - m_sk[1], ma - m_sk[0]};
    endfunction

    // RC5 key expansion for an all-zero 16-byte key.
    task automatic build_sched();
        logic [31:0] l [4];
        logic [31:0] ka, kb;
        int i, j;
        sched[0] = 32'hB7E15163;
        for (int k = 1; k < NSK; k++) sched[k] = sched[k-1] + 32'h9E3779B9;
        for (int k = 0; k < 4; k++) l[k] = '0;
        ka = '0; kb = '0; i = 0; j = 0;
        for (int k = 0; k < 3 * NSK; k++) begin
            ka = rl(sched[i] + ka + kb, 32'd3);
            sched[i] = ka;
            kb = rl(l[j] + ka + kb, ka + kb);
            l[j] = kb;
            i = (i + 1) % NSK;
            j = (j + 1) % 4;
        end
    endtask

    // Compare process: one block in flight at most; outputs checked every cycle.
    always @(negedge clk) begin
        int rc;
        if (model_on) begin
            if (exp_q.size() != 0) begin
                if (wait_cnt > 0) wait_cnt--;
                if (wait_cnt > 0) begin
                    check("busy_flags", {out_valid, in_ready, busy}, 3'b001);
                end else begin
                    check("done_flags", {out_valid, in_ready, busy}, 3'b101);
                    check("out_data", out_data, exp_q[0]);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end else begin
                check("idle_flags", {out_valid, in_ready, busy}, 3'b010);
                if (in_valid) begin
                    rc = (int'(in_rounds) > MR) ? MR : int'(in_rounds);
                    exp_q.push_back(in_decrypt ? m_dec(in_data, rc) : m_enc(in_data, rc));
                    wait_cnt = rc + 1;
                end
                if (sk_we && int'(sk_addr) < NSK) m_sk[sk_addr] = sk_wdata;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic write_sk(input int addr, input logic [31:0] data);
        sk_we = 1'b1; sk_addr = SKW'(addr); sk_wdata = data;
        @(posedge clk); #1;
        sk_we = 1'b0;
    endtask

    task automatic run_block(input bit d, input int rounds, input logic [63:0] din,
                             input int hold, output logic [63:0] res, output int lat,
                             output int acc);
        res = '0; lat = 0; acc = 0;
        in_valid = 1'b1; in_decrypt = d; in_rounds = RW'(rounds); in_data = din;
        @(negedge clk);
        while (!in_ready && acc < 100) begin @(negedge clk); acc++; end
        if (!in_ready) begin fail_now("accept"); in_valid = 1'b0; return; end
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = (hold == 0);
        do begin @(negedge clk); lat++; end while (!out_valid && lat < 100);
        if (!out_valid) begin fail_now("out_valid"); out_ready = 1'b0; return; end
        res = out_data;
        if (hold > 0) begin
            repeat (hold) @(posedge clk);
            #1 out_ready = 1'b1;
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic reset_and_release();
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        wait_cnt = 0;
        for (int k = 0; k < NSK; k++) m_sk[k] = '0;
        @(posedge clk); #1;
        check("in_ready_after_release", in_ready, 1'b1);
        model_on = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [63:0] res, p, c, dd, kat;
        int lat, acc, r;
        kat = 64'h6D8F4B15_EEDBA521;
        rst = 1'b0; sk_we = 1'b0; sk_addr = '0; sk_wdata = '0;
        in_valid = 1'b0; in_decrypt = 1'b0; in_rounds = '0; in_data = '0; out_ready = 1'b0;
        model_on = 1'b0; wait_cnt = 0;
        for (int k = 0; k < NSK; k++) m_sk[k] = '0;

        #12;
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_out_data", out_data, 64'h0);
        reset_and_release();

        build_sched();
        for (int k = 0; k < NSK; k++) write_sk(k, sched[k]);

        run_block(0, 12, 64'h0, 0, res, lat, acc);
        check("kat_enc", res, kat);
        check("kat_enc_latency", lat, 13);
        run_block(1, 12, kat, 0, res, lat, acc);
        check("kat_dec", res, 64'h0);
        check("kat_dec_latency", lat, 13);

        // Round count above the maximum saturates.
        run_block(0, MR + 3, 64'h0, 0, res, lat, acc);
        check("rounds_clamp", res, kat);
        check("rounds_clamp_latency", lat, 13);

        // Backpressure, then the next block goes straight in.
        p = {$urandom(), $urandom()};
        run_block(0, 5, p, 10, res, lat, acc);
        check("bp_latency", lat, 6);
        run_block(0, 3, p, 0, res, lat, acc);
        check("accept_after_bp", acc, 0);

        // Subkey writes while busy or out of range are dropped.
        fork
            run_block(0, 12, 64'h0, 0, res, lat, acc);
            begin
                @(posedge clk); #1;
                for (int k = 0; k < 4; k++) begin
                    sk_we = 1'b1; sk_addr = SKW'(k); sk_wdata = $urandom();
                    @(posedge clk); #1;
                end
                sk_we = 1'b0;
            end
        join
        check("sk_write_in_round", res, kat);
        write_sk(26, $urandom());
        write_sk(31, $urandom());
        run_block(0, 12, 64'h0, 0, res, lat, acc);
        check("sk_write_out_of_range", res, kat);

        for (int n = 0; n < 1000; n++) begin
            p = {$urandom(), $urandom()};
            r = $urandom_range(0, 15);
            run_block(0, r, p, $urandom_range(0, 2), c, lat, acc);
            run_block(1, r, c, $urandom_range(0, 2), dd, lat, acc);
            check("roundtrip", dd, p);
        end

        // Whitening-only blocks with small hand-set subkeys.
        write_sk(0, 32'd1);
        write_sk(1, 32'd2);
        run_block(0, 0, 64'h00000003_00000005, 0, res, lat, acc);
        check("r0_enc", res, 64'h00000005_00000006);
        check("r0_enc_latency", lat, 1);
        run_block(1, 0, 64'h00000005_00000006, 0, res, lat, acc);
        check("r0_dec", res, 64'h00000003_00000005);
        check("r0_dec_latency", lat, 1);

        // Reset while the result is held in DONE.
        in_valid = 1'b1; in_decrypt = 1'b0; in_rounds = 4'd2; in_data = 64'h1;
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("done_before_reset", out_valid, 1'b1);
        model_on = 1'b0;
        rst = 1'b0;
        #1;
        check("reset_done_out_valid", out_valid, 1'b0);
        check("reset_done_busy", busy, 1'b0);
        reset_and_release();

        // Reset mid-ROUND: subkey table is cleared as well.
        for (int k = 0; k < 6; k++) write_sk(k, $urandom());
        in_valid = 1'b1; in_decrypt = 1'b0; in_rounds = 4'd12; in_data = {$urandom(), $urandom()};
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("busy_mid_round", busy, 1'b1);
        model_on = 1'b0;
        rst = 1'b0;
        #1;
        check("reset_round_out_valid", out_valid, 1'b0);
        check("reset_round_in_ready", in_ready, 1'b0);
        check("reset_round_busy", busy, 1'b0);
        check("reset_round_out_data", out_data, 64'h0);
        reset_and_release();
        p = 64'h12345678_9ABCDEF0;
        run_block(0, 0, p, 0, res, lat, acc);
        check("zero_key_r0", res, p);
        run_block(0, 12, p, 0, res, lat, acc);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
